// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, entry type and sizing helper for fetch_queue
package fetch_pkg;

    localparam logic [5:0] OPC_J = 6'b000010;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } fetch_entry_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo_mem.sv
// rtl/fetch_fifo_mem.sv - prefetch entry storage with wrapping pointers and occupancy count
module fetch_fifo_mem
    import fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [cnt_w(DEPTH)-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Entry payload needs no reset; only the pointers and count decide validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch stage owning the PC, feeding decode through a flushable prefetch queue (option: FETCH_JUMP_PREDECODE_EN)
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     CLK,
    input  logic                     NRST,
    output logic [ADDR_W-1:0]        INST_ADDR,
    input  logic [INST_W-1:0]        INST,
    input  logic                     INST_VALID,
    input  logic                     REDIRECT,
    input  logic [ADDR_W-1:0]        REDIRECT_PC,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [INST_W-1:0]        OUT_INST,
    output logic [ADDR_W-1:0]        OUT_PC4,
    output logic [cnt_w(DEPTH)-1:0]  OUT_COUNT
);

    localparam int CNT_W = cnt_w(DEPTH);
    localparam int ENT_W = INST_W + ADDR_W;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] next_pc;
    logic              full;
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  head;

    assign pc4       = pc + ADDR_W'(4);
    assign INST_ADDR = pc;

`ifdef FETCH_JUMP_PREDECODE_EN
    // Follow J immediately so decode never has to redirect for it.
    always_comb begin
        next_pc = pc4;
        if (INST[31:26] == OPC_J) begin
            next_pc = {pc4[ADDR_W-1:28], INST[25:0], 2'b00};
        end
    end
`else
    assign next_pc = pc4;
`endif

    assign full = (OUT_COUNT == CNT_W'(DEPTH));
    assign pop  = OUT_VALID & OUT_READY & ~REDIRECT;
    assign push = INST_VALID & ~REDIRECT & (~full | pop);

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            pc <= RESET_PC;
        end else if (REDIRECT) begin
            pc <= REDIRECT_PC;
        end else if (push) begin
            pc <= next_pc;
        end
    end

    fetch_fifo_mem #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (CLK),
        .rst_n   (NRST),
        .push    (push),
        .pop     (pop),
        .flush   (REDIRECT),
        .wr_data ({INST, pc4}),
        .rd_data (head),
        .count   (OUT_COUNT)
    );

    // Empty queue presents a nop with a zero PC so stale storage never leaks out.
    assign OUT_VALID = (OUT_COUNT != '0);
    assign OUT_INST  = OUT_VALID ? head[ENT_W-1:ADDR_W] : '0;
    assign OUT_PC4   = OUT_VALID ? head[ADDR_W-1:0]     : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue: vector table, corner sequences, random vs queue model
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = cnt_w(DEPTH);

    logic          CLK;
    logic          NRST;
    logic [31:0]   INST_ADDR;
    logic [31:0]   INST;
    logic          INST_VALID;
    logic          REDIRECT;
    logic [31:0]   REDIRECT_PC;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [31:0]   OUT_INST;
    logic [31:0]   OUT_PC4;
    logic [CW-1:0] OUT_COUNT;

    logic          ovr_en;
    logic [31:0]   ovr_inst;

    int checks = 0;
    int errors = 0;

    fetch_queue #(
        .ADDR_W   (32),
        .INST_W   (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .CLK         (CLK),
        .NRST        (NRST),
        .INST_ADDR   (INST_ADDR),
        .INST        (INST),
        .INST_VALID  (INST_VALID),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .OUT_INST    (OUT_INST),
        .OUT_PC4     (OUT_PC4),
        .OUT_COUNT   (OUT_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Instruction memory image: bit 31 set so no word ever decodes as J.
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        logic [31:0] h;
        h = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        return {1'b1, h[30:0]};
    endfunction

    assign INST = ovr_en ? ovr_inst : inst_of(INST_ADDR);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_outs(input string tag, input logic [31:0] addr, input logic v,
                              input logic [31:0] pc4, input int cnt);
        check({tag, ".addr"},  INST_ADDR, addr);
        check({tag, ".valid"}, 32'(OUT_VALID), 32'(v));
        check({tag, ".pc4"},   OUT_PC4, pc4);
        check({tag, ".inst"},  OUT_INST, v ? inst_of(pc4 - 32'd4) : 32'h0);
        check({tag, ".count"}, 32'(OUT_COUNT), 32'(cnt));
    endtask

    task automatic do_reset();
        INST_VALID = 1'b0; OUT_READY = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = '0; ovr_en = 1'b0;
        @(posedge CLK); #1;
        NRST = 1'b0;
        #2;
        NRST = 1'b1;
    endtask

    typedef struct {
        logic        iv;
        logic        rdy;
        logic        rd;
        logic [31:0] rpc;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc4;
        int          cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic iv, input logic rdy, input logic rd, input logic [31:0] rpc,
                       input logic [31:0] addr, input logic v, input logic [31:0] pc4, input int cnt);
        vec_t e;
        e.iv = iv; e.rdy = rdy; e.rd = rd; e.rpc = rpc;
        e.addr = addr; e.v = v; e.pc4 = pc4; e.cnt = cnt;
        tbl.push_back(e);
    endtask

    fetch_entry_t mq[$];
    logic [31:0]  mpc;

    initial begin
        logic m_push;
        logic m_pop;
        fetch_entry_t e;

        ovr_en = 1'b0; ovr_inst = '0;
        INST_VALID = 1'b0; OUT_READY = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = '0;
        NRST = 1'b0;
        #3;
        check_outs("reset", 32'h0, 1'b0, 32'h0, 0);
        NRST = 1'b1;

        // streaming, fill to full, full with pop, drain, redirect, wrap at top of address space
        add(1,1,0,0,            32'h4,        1, 32'h4,        1);
        add(1,1,0,0,            32'h8,        1, 32'h8,        1);
        add(1,1,0,0,            32'hC,        1, 32'hC,        1);
        add(1,1,0,0,            32'h10,       1, 32'h10,       1);
        add(1,0,0,0,            32'h14,       1, 32'h10,       2);
        add(1,0,0,0,            32'h18,       1, 32'h10,       3);
        add(1,0,0,0,            32'h1C,       1, 32'h10,       4);
        add(1,0,0,0,            32'h1C,       1, 32'h10,       4);
        add(1,1,0,0,            32'h20,       1, 32'h14,       4);
        add(0,1,0,0,            32'h20,       1, 32'h18,       3);
        add(0,1,1,32'h100,      32'h100,      0, 32'h0,        0);
        add(1,0,0,0,            32'h104,      1, 32'h104,      1);
        add(0,1,0,0,            32'h104,      0, 32'h0,        0);
        add(1,1,0,0,            32'h108,      1, 32'h108,      1);
        add(0,1,0,0,            32'h108,      0, 32'h0,        0);
        add(1,1,1,32'hFFFF_FFF8,32'hFFFF_FFF8,0, 32'h0,        0);
        add(1,1,0,0,            32'hFFFF_FFFC,1, 32'hFFFF_FFFC,1);
        add(1,1,0,0,            32'h0,        1, 32'h0,        1);
        add(1,1,0,0,            32'h4,        1, 32'h4,        1);

        @(posedge CLK); #1;
        for (int i = 0; i < tbl.size(); i++) begin
            INST_VALID  = tbl[i].iv;
            OUT_READY   = tbl[i].rdy;
            REDIRECT    = tbl[i].rd;
            REDIRECT_PC = tbl[i].rpc;
            @(posedge CLK); #1;
            check_outs($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].v, tbl[i].pc4, tbl[i].cnt);
        end

        // jump predecode: J at PC 0 targeting 0x100
        do_reset();
        ovr_en = 1'b1; ovr_inst = 32'h0800_0040;
        INST_VALID = 1'b1; OUT_READY = 1'b0;
        @(posedge CLK); #1;
        INST_VALID = 1'b0; ovr_en = 1'b0;
`ifdef FETCH_JUMP_PREDECODE_EN
        check("jmp.addr", INST_ADDR, 32'h100);
`else
        check("jmp.addr", INST_ADDR, 32'h4);
`endif
        check("jmp.pc4",  OUT_PC4,  32'h4);
        check("jmp.inst", OUT_INST, 32'h0800_0040);
        check("jmp.count", 32'(OUT_COUNT), 32'd1);

        // asynchronous reset while full, between clock edges
        do_reset();
        INST_VALID = 1'b1; OUT_READY = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        check("full.count", 32'(OUT_COUNT), 32'd4);
        check("full.addr",  INST_ADDR, 32'h10);
        #1;
        NRST = 1'b0;
        #1;
        check_outs("async_rst", 32'h0, 1'b0, 32'h0, 0);
        INST_VALID = 1'b0;
        #1;
        NRST = 1'b1;

        // randomized traffic against a queue model
        mq.delete();
        mpc = 32'h0;
        @(posedge CLK); #1;
        for (int c = 0; c < 400; c++) begin
            INST_VALID  = ($urandom_range(0, 3) != 0);
            OUT_READY   = ($urandom_range(0, 2) != 0);
            REDIRECT    = ($urandom_range(0, 15) == 0);
            REDIRECT_PC = $urandom & 32'hFFFF_FFFC;
            #1;
            check($sformatf("rnd%0d.addr", c), INST_ADDR, mpc);
            m_pop  = (mq.size() != 0) && OUT_READY && !REDIRECT;
            m_push = INST_VALID && !REDIRECT && ((mq.size() < DEPTH) || m_pop);
            if (REDIRECT) begin
                mq.delete();
                mpc = REDIRECT_PC;
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_push) begin
                    e.inst = inst_of(mpc);
                    e.pc4  = mpc + 32'd4;
                    mq.push_back(e);
                    mpc = mpc + 32'd4;
                end
            end
            @(posedge CLK); #1;
            check($sformatf("rnd%0d.count", c), 32'(OUT_COUNT), 32'(mq.size()));
            check($sformatf("rnd%0d.valid", c), 32'(OUT_VALID), 32'(mq.size() != 0));
            check($sformatf("rnd%0d.inst", c), OUT_INST, (mq.size() != 0) ? mq[0].inst : 32'h0);
            check($sformatf("rnd%0d.pc4", c),  OUT_PC4,  (mq.size() != 0) ? mq[0].pc4  : 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
